// File: rtl/lpe_request_sequencer.sv
// -----------------------------------------------------------------------------
// lpe_request_sequencer
//
// Purpose:
//   Latches a 16-bit multi-hot request vector and serves its set bits one at a
//   time, lowest index first, as 4-bit indices on a valid/ready handshake.
//   Each accepted index clears its bit; once the vector is empty the block
//   returns to IDLE and pulses done for one cycle.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   load_valid_i   a new request vector is offered
//   load_ready_o   block can accept a vector (IDLE only)
//   load_vec_i     request vector, sampled on the load handshake
//   idx_valid_o    an index is offered (SCAN only)
//   idx_ready_i    consumer accepts the offered index
//   idx_o          lowest set bit of pending (0 when idx_valid_o is low)
//   pending_o      remaining unserved request bits (registered)
//   busy_o         high while scanning
//   done_o         one-cycle pulse after the vector is fully served
//   flush_i        (LPE_SEQ_FLUSH_EN only) abandon the current vector
//
// Configuration:
//   LPE_SEQ_FLUSH_EN  when defined, adds flush_i. A flush in SCAN empties the
//                     vector and returns to IDLE without a done pulse; in IDLE
//                     it blocks a simultaneous load.
// -----------------------------------------------------------------------------
module lpe_request_sequencer #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_vec_i,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] pending_o,
    output logic             busy_o,
`ifdef LPE_SEQ_FLUSH_EN
    input  logic             flush_i,
`endif
    output logic             done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   pending_q;
    logic [WIDTH-1:0]   pending_d;
    logic               done_q;
    logic [IDX_W-1:0]   lowIdx;
    logic               lastBit;
    logic               flushReq;

`ifdef LPE_SEQ_FLUSH_EN
    assign flushReq = flush_i;
`else
    assign flushReq = 1'b0;
`endif

    // Priority encoder over the pending register. Walking from the top bit
    // down lets the lowest set bit win, so bit 0 has priority.
    always_comb begin
        lowIdx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowIdx = IDX_W'(i);
            end
        end
    end

    // Vector after the currently offered bit is served. If clearing the
    // lowest bit leaves nothing, this handshake finishes the vector.
    assign pending_d = pending_q & ~(WIDTH'(1) << lowIdx);
    assign lastBit   = (pending_d == '0);

    // Sequencer FSM. IDLE accepts vectors (a zero vector completes at once);
    // SCAN drains pending one handshake at a time. done is registered so it
    // appears in the cycle after the completing edge, alongside load_ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_valid_i && !flushReq) begin
                        if (load_vec_i != '0) begin
                            pending_q <= load_vec_i;
                            state_q   <= SCAN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (flushReq) begin
                        pending_q <= '0;
                        state_q   <= IDLE;
                    end else if (idx_ready_i) begin
                        pending_q <= pending_d;
                        if (lastBit) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= '0;
                end
            endcase
        end
    end

    // All handshake outputs decode registered state only, so idx_ready_i has
    // no combinational path to idx_valid_o or idx_o.
    assign load_ready_o = (state_q == IDLE);
    assign idx_valid_o  = (state_q == SCAN);
    assign busy_o       = (state_q == SCAN);
    assign idx_o        = (state_q == SCAN) ? lowIdx : '0;
    assign pending_o    = pending_q;
    assign done_o       = done_q;

endmodule

// File: doc/lpe_request_sequencer.md
# lpe_request_sequencer

Downstream consumer of the 16-to-4 low-priority encoder stage. It latches a 16-bit request vector and serves every set bit, lowest index first, as a stream of 4-bit indices on a valid/ready handshake. Each served bit is cleared until the vector is empty, then the block signals completion. Typical use: converting a multi-hot request word into a sequence of one-at-a-time service slots.

## Interface
- WIDTH, 16, request vector width; only 16 is supported.
- IDX_W, 4, index width; must equal log2(WIDTH).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  new request vector offered.
- load_ready  out  1  block can accept a vector; high only in IDLE.
- load_vec  in  16  request vector, sampled on load handshake.
- idx_valid  out  1  an index is offered; high only in SCAN.
- idx_ready  in  1  consumer accepts the offered index.
- idx  out  4  lowest set bit of pending; 0 when idx_valid is low.
- pending  out  16  remaining unserved request bits (registered).
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse: current vector fully served.

## Operation
- States: IDLE, SCAN.
- IDLE: load_ready=1, idx_valid=0.
  - Load handshake with load_vec≠0: pending←load_vec, go to SCAN.
  - Load handshake with load_vec=0: pending stays 0, stay in IDLE, done=1 in the next cycle.
- SCAN: idx_valid=1. idx is combinational from the pending register and equals the lowest set bit index (bit 0 has priority).
  - Index handshake: clear pending[idx].
  - If that bit was the last set bit: go to IDLE, done=1 in the next cycle.
- idx and pending hold stable while idx_valid=1 and idx_ready=0.
- load_valid is ignored in SCAN; there is no queueing.
- Reset values (asynchronous, applied immediately while rst=1):
  - state=IDLE, pending=0, done=0, busy=0, idx_valid=0, idx=0.
  - load_ready=1, because it is decoded from IDLE.
- Reset during SCAN discards the vector with no done pulse.

## Timing
- Load handshake at edge N → idx_valid=1 and idx valid in cycle N+1; load-to-first-index latency is 1 cycle.
- With idx_ready held high, one index per cycle; k set bits drain in k cycles.
- done is a registered pulse, high exactly one cycle after the final index handshake edge, or after a zero-vector load edge.
- done coincides with load_ready=1, so a new vector may be loaded in the done cycle.
- Back-to-back vector throughput: k+1 cycles per vector with k≥1 bits.
- No combinational path from idx_ready to idx_valid or idx; both depend only on registered state.
- load_ready depends on state only.

## Configuration
- Macro LPE_SEQ_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 at an edge in SCAN: pending←0, go to IDLE, no done pulse.
  - A simultaneous index handshake is discarded.
  - flush in IDLE has no effect; it overrides a simultaneous load.
- Undefined: the flush port does not exist; the only way to abandon a vector is rst.

## Test plan
- Reset, load 16'h0001, idx_ready=1 → next cycle idx_valid=1, idx=0; after the handshake, done pulses one cycle, pending=0, load_ready=1.
- Load 16'h0154, idx_ready held 1 → idx 2, 4, 6, 8 on 4 consecutive cycles; done in the 5th cycle.
- Load 16'h5558 with idx_ready toggling 1/0 → idx sequence 3, 4, 6, 8, 10, 12, 14; idx and pending stable in every stall cycle; exactly one done.
- Load 16'h0000 → idx_valid never rises; done=1 in the cycle after load; load_ready stays 1.
- Load 16'h8000, stall idx_ready=0, assert rst for 1 cycle → outputs immediately at reset values, no done. After release, load 16'h0002 → idx=1.
- (LPE_SEQ_FLUSH_EN) Load 16'hFFFF, accept idx 0 and 1, then flush=1 → next cycle IDLE, pending=0, no done. Load 16'h0010 → idx=4.
